// File: rtl/filter_bank_loader_pkg.sv
// Shared types and constants for the biquad coefficient loader:
// coefficient set layout, reset defaults, byte offsets and control addresses.
package filter_pkg;

   typedef struct packed {
      logic [31:0] rate;
      logic [39:0] cx;
      logic [7:0]  cx0;
      logic [7:0]  cx1;
      logic [7:0]  cx2;
      logic [23:0] cy0;
      logic [23:0] cy1;
      logic [23:0] cy2;
   } coeff_set_t;

   // One section's host-visible byte window, byte 0 at index 0.
   typedef logic [31:0][7:0] byte_map_t;

   typedef enum logic {
      ST_IDLE,
      ST_PENDING
   } load_state_t;

   localparam coeff_set_t DEFAULT_SET = '{
      rate: 32'd7056000,
      cx:   40'd4258969,
      cx0:  8'd3,
      cx1:  8'd3,
      cx2:  8'd1,
      cy0:  24'(-6216759),
      cy1:  24'd6143386,
      cy2:  24'(-2023767)
   };

   localparam logic [4:0] OFS_RATE = 5'h00;
   localparam logic [4:0] OFS_CX   = 5'h04;
   localparam logic [4:0] OFS_CX0  = 5'h0C;
   localparam logic [4:0] OFS_CX1  = 5'h0D;
   localparam logic [4:0] OFS_CX2  = 5'h0E;
   localparam logic [4:0] OFS_CY0  = 5'h0F;
   localparam logic [4:0] OFS_CY1  = 5'h13;
   localparam logic [4:0] OFS_CY2  = 5'h17;

   localparam logic [7:0] CMD_DEFAULTS = 8'hFE;
   localparam logic [7:0] CMD_COMMIT   = 8'hFF;

   // Reserved bytes stay zero so they read back as 0.
   function automatic byte_map_t pack_bytes(input coeff_set_t c);
      byte_map_t b;
      b = '0;
      b[OFS_RATE +: 4] = c.rate;
      b[OFS_CX   +: 5] = c.cx;
      b[OFS_CX0]       = c.cx0;
      b[OFS_CX1]       = c.cx1;
      b[OFS_CX2]       = c.cx2;
      b[OFS_CY0  +: 3] = c.cy0;
      b[OFS_CY1  +: 3] = c.cy1;
      b[OFS_CY2  +: 3] = c.cy2;
      return b;
   endfunction

   // Reserved bytes are simply dropped, which is what makes writes to them no-ops.
   function automatic coeff_set_t unpack_bytes(input byte_map_t b);
      coeff_set_t c;
      c.rate = b[OFS_RATE +: 4];
      c.cx   = b[OFS_CX   +: 5];
      c.cx0  = b[OFS_CX0];
      c.cx1  = b[OFS_CX1];
      c.cx2  = b[OFS_CX2];
      c.cy0  = b[OFS_CY0  +: 3];
      c.cy1  = b[OFS_CY1  +: 3];
      c.cy2  = b[OFS_CY2  +: 3];
      return c;
   endfunction

endpackage

// File: rtl/filter_bank_loader_if.sv
// Byte-wide host bus between the bridge write decoder and the coefficient loader.
interface filter_bank_loader_if;
   import filter_pkg::*;

   logic       afilter_wr;
   logic [7:0] afilter_addr;
   logic [7:0] afilter_din;
   logic       afilter_rd;
   logic [7:0] afilter_dout;

   modport master (
      output afilter_wr,
      output afilter_addr,
      output afilter_din,
      output afilter_rd,
      input  afilter_dout
   );

   modport slave (
      input  afilter_wr,
      input  afilter_addr,
      input  afilter_din,
      input  afilter_rd,
      output afilter_dout
   );

endinterface

// File: rtl/filter_bank_loader_bank.sv
// One biquad section's shadow coefficient set: byte write decode and
// combinational byte readback for the top-level readback register.
module filter_coeff_bank
   import filter_pkg::*;
(
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       load_defaults,
   input  logic       wr_en,
   input  logic [4:0] offset,
   input  logic [7:0] din,
   output logic [7:0] rd_byte,
   output coeff_set_t shadow
);

   byte_map_t cur_bytes;
   byte_map_t nxt_bytes;

   always_comb begin
      cur_bytes         = pack_bytes(shadow);
      nxt_bytes         = cur_bytes;
      nxt_bytes[offset] = din;
      rd_byte           = cur_bytes[offset];
   end

   always_ff @(posedge clk_sys) begin
      if (reset || load_defaults) begin
         shadow <= DEFAULT_SET;
      end else if (wr_en) begin
         shadow <= unpack_bytes(nxt_bytes);
      end
   end

endmodule

// File: rtl/filter_bank_loader.sv
// Double-buffered coefficient loader for a cascade of biquad sections: host writes
// fill shadow banks, a commit moves all sections to the active bank on the sample strobe.
module filter_bank_loader
   import filter_pkg::*;
#(
   parameter int NUM_SECTIONS = 2,
   parameter int TIMEOUT      = 4095
) (
   input  logic                        clk_sys,
   input  logic                        reset,
   filter_bank_loader_if.slave         bus,
   input  logic                        sample_tick,
   output logic [32*NUM_SECTIONS-1:0]  flt_rate,
   output logic [40*NUM_SECTIONS-1:0]  cx,
   output logic [8*NUM_SECTIONS-1:0]   cx0,
   output logic [8*NUM_SECTIONS-1:0]   cx1,
   output logic [8*NUM_SECTIONS-1:0]   cx2,
   output logic [24*NUM_SECTIONS-1:0]  cy0,
   output logic [24*NUM_SECTIONS-1:0]  cy1,
   output logic [24*NUM_SECTIONS-1:0]  cy2,
   output logic                        pending,
   output logic                        coeff_updated
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [2:0]       sec;
   logic [4:0]       ofs;
   logic             ctrl_addr;
   logic             cmd_defaults;
   logic             cmd_commit;
   logic [7:0]       rd_mux;
   logic             timeout_hit;
   load_state_t      state;
   logic [CNT_W-1:0] timeout_cnt;

   logic [NUM_SECTIONS-1:0] bank_wr;
   logic [7:0]              bank_rd [NUM_SECTIONS];
   coeff_set_t              shadow_set [NUM_SECTIONS];
   coeff_set_t              active_set [NUM_SECTIONS];

   assign sec          = bus.afilter_addr[7:5];
   assign ofs          = bus.afilter_addr[4:0];
   assign ctrl_addr    = (bus.afilter_addr == CMD_DEFAULTS) || (bus.afilter_addr == CMD_COMMIT);
   assign cmd_defaults = bus.afilter_wr && (bus.afilter_addr == CMD_DEFAULTS);
   assign cmd_commit   = bus.afilter_wr && (bus.afilter_addr == CMD_COMMIT);

   // The counter holds the PENDING cycles already elapsed, so the forced apply
   // lands exactly TIMEOUT cycles after the commit write.
   assign timeout_hit = (timeout_cnt == CNT_W'(TIMEOUT - 1));

   for (genvar s = 0; s < NUM_SECTIONS; s++) begin : g_sec
      assign bank_wr[s] = bus.afilter_wr && !ctrl_addr && (sec == 3'(s));

      filter_coeff_bank u_bank (
         .clk_sys       (clk_sys),
         .reset         (reset),
         .load_defaults (cmd_defaults),
         .wr_en         (bank_wr[s]),
         .offset        (ofs),
         .din           (bus.afilter_din),
         .rd_byte       (bank_rd[s]),
         .shadow        (shadow_set[s])
      );

      assign flt_rate[32*s +: 32] = active_set[s].rate;
      assign cx[40*s +: 40]       = active_set[s].cx;
      assign cx0[8*s +: 8]        = active_set[s].cx0;
      assign cx1[8*s +: 8]        = active_set[s].cx1;
      assign cx2[8*s +: 8]        = active_set[s].cx2;
      assign cy0[24*s +: 24]      = active_set[s].cy0;
      assign cy1[24*s +: 24]      = active_set[s].cy1;
      assign cy2[24*s +: 24]      = active_set[s].cy2;
   end

   // Unimplemented sections and the control addresses read back as zero.
   always_comb begin
      rd_mux = '0;
      for (int s = 0; s < NUM_SECTIONS; s++) begin
         if (!ctrl_addr && (sec == 3'(s))) begin
            rd_mux = bank_rd[s];
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         bus.afilter_dout <= '0;
      end else if (bus.afilter_rd) begin
         bus.afilter_dout <= rd_mux;
      end
   end

   // A commit always wins over a same-cycle tick so the new request is never
   // applied from a half-written shadow; it waits for the following tick.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state         <= ST_IDLE;
         timeout_cnt   <= '0;
         pending       <= 1'b0;
         coeff_updated <= 1'b0;
         for (int s = 0; s < NUM_SECTIONS; s++) begin
            active_set[s] <= DEFAULT_SET;
         end
      end else begin
         coeff_updated <= 1'b0;
         if (cmd_commit) begin
            state       <= ST_PENDING;
            pending     <= 1'b1;
            timeout_cnt <= '0;
         end else begin
            case (state)
               ST_PENDING: begin
                  if (sample_tick || timeout_hit) begin
                     for (int s = 0; s < NUM_SECTIONS; s++) begin
                        active_set[s] <= shadow_set[s];
                     end
                     state         <= ST_IDLE;
                     pending       <= 1'b0;
                     coeff_updated <= 1'b1;
                     timeout_cnt   <= '0;
                  end else begin
                     timeout_cnt <= timeout_cnt + CNT_W'(1);
                  end
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule
